// File: rtl/result_bcd_converter_pkg.sv
// Shared types and default sizing for the multiplier result BCD converter.
package result_pkg;

    // Converter sequencing states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default sizing: 14-bit magnitude (127*127 max) needs 5 decimal digits
    localparam int unsigned RESULT_WIDTH  = 14;
    localparam int unsigned RESULT_DIGITS = 5;
    localparam int unsigned BCD_DIGIT_W   = 4;

endpackage

// File: rtl/result_bcd_converter_bcd_digit_adjust.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before shift.
module bcd_digit_adjust
    import result_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Pre-shift correction so the doubled digit carries correctly into the next
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_DIGIT_W'(5)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (one bit per clock) with leading-zero
// blanking mask and signed-zero suppression for the seven-segment driver.
module result_bcd_converter
    import result_pkg::*;
#(
    parameter int unsigned WIDTH  = RESULT_WIDTH,
    parameter int unsigned DIGITS = RESULT_DIGITS
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          sign_in,
    input  logic [WIDTH-1:0]              magnitude,
    output logic                          busy,
    output logic                          done,
    output logic                          sign_out,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]             blank
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   bin_sr;
    logic [BCD_W-1:0]   work;
    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   work_next;
    logic [CNT_W-1:0]   count;
    logic               sign_r;
    logic               nonzero_r;
    logic               last_iter;
    logic [DIGITS-1:0]  blank_next;
    logic               all_zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_in  (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One double-dabble iteration: corrected digits shift left, binary MSB enters
    always_comb begin
        work_next = (work_adj << 1) | BCD_W'(bin_sr[WIDTH-1]);
    end

    // Blank mask from the final digits: scan from the top while digits stay zero
    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            all_zero = all_zero && (work_next[(DIGITS-1-i)*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            blank_next[DIGITS-1-i] = all_zero;
        end
        blank_next[0] = 1'b0;
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and busy decode; last iteration is when the counter holds 1
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        last_iter  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == CNT_W'(1)) begin
                    last_iter  = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Datapath: latch on accept, iterate in SHIFT, publish results on the last step
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bin_sr    <= '0;
            work      <= '0;
            count     <= '0;
            sign_r    <= 1'b0;
            nonzero_r <= 1'b0;
            done      <= 1'b0;
            sign_out  <= 1'b0;
            bcd       <= '0;
            blank     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr    <= magnitude;
                        sign_r    <= sign_in;
                        nonzero_r <= |magnitude;
                        work      <= '0;
                        count     <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    work   <= work_next;
                    bin_sr <= bin_sr << 1;
                    count  <= count - CNT_W'(1);
                    if (last_iter) begin
                        bcd      <= work_next;
                        blank    <= blank_next;
                        sign_out <= sign_r & nonzero_r;
                        done     <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter against a decimal arithmetic model.
module tb_result_bcd_converter;

    localparam int unsigned W = 14;
    localparam int unsigned D = 5;

    logic             clock;
    logic             reset_n;
    logic             start;
    logic             sign_in;
    logic [W-1:0]     magnitude;
    logic             busy;
    logic             done;
    logic             sign_out;
    logic [4*D-1:0]   bcd;
    logic [D-1:0]     blank;

    int unsigned n_checks;
    int unsigned n_pass;

    logic [4*D-1:0]   last_bcd;
    logic [D-1:0]     last_blank;
    logic             last_sign;

    result_bcd_converter #(
        .WIDTH  (W),
        .DIGITS (D)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .sign_in   (sign_in),
        .magnitude (magnitude),
        .busy      (busy),
        .done      (done),
        .sign_out  (sign_out),
        .bcd       (bcd),
        .blank     (blank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Decimal digits by division, packed units-first
    function automatic logic [4*D-1:0] model_bcd(input int unsigned m);
        logic [4*D-1:0] r;
        int unsigned    p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i and everything above it are zero exactly when m < 10^i (i >= 1)
    function automatic logic [D-1:0] model_blank(input int unsigned m);
        logic [D-1:0] r;
        int unsigned  p;
        r = '0;
        p = 10;
        for (int i = 1; i < D; i++) begin
            r[i] = (m < p);
            p = p * 10;
        end
        return r;
    endfunction

    // Waits from the accepting edge until done, counting edges; inputs must be
    // driven before the call. Optionally re-asserts start mid-conversion.
    task automatic accept_and_wait(input int inject_at, output int lat);
        @(posedge clock);
        #1;
        start     = 1'b0;
        magnitude = W'($urandom);
        sign_in   = 1'($urandom);
        check("busy_on_accept", 32'(busy), 32'd1);
        check("done_low_on_accept", 32'(done), 32'd0);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
            start = 1'b0;
            if (lat == inject_at) begin
                start     = 1'b1;
                magnitude = W'(99);
            end
            if (lat == 7) begin
                check("hold_bcd_in_shift", 32'(bcd), 32'(last_bcd));
                check("hold_blank_in_shift", 32'(blank), 32'(last_blank));
                check("busy_in_shift", 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic check_result(input int unsigned m, input logic s, input int lat);
        check("latency", 32'(lat), 32'(W));
        check("bcd", 32'(bcd), 32'(model_bcd(m)));
        check("blank", 32'(blank), 32'(model_blank(m)));
        check("sign_out", 32'(sign_out), 32'(s && (m != 0)));
        check("busy_at_done", 32'(busy), 32'd0);
        last_bcd   = model_bcd(m);
        last_blank = model_blank(m);
        last_sign  = s && (m != 0);
    endtask

    task automatic run_one(input int unsigned m, input logic s);
        int lat;
        @(negedge clock);
        start     = 1'b1;
        magnitude = W'(m);
        sign_in   = s;
        accept_and_wait(-1, lat);
        check_result(m, s, lat);
        @(posedge clock);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int unsigned m;
        int unsigned done_count;
        logic s;

        n_checks   = 0;
        n_pass     = 0;
        last_bcd   = '0;
        last_blank = '0;
        last_sign  = 1'b0;
        reset_n    = 1'b0;
        start      = 1'b0;
        sign_in    = 1'b0;
        magnitude  = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_blank", 32'(blank), 32'd0);
        check("rst_sign", 32'(sign_out), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases from the plan
        run_one(16129, 1'b1);
        run_one(0, 1'b1);
        run_one(16383, 1'b0);
        run_one(42, 1'b1);

        // start during SHIFT is ignored
        @(negedge clock);
        start     = 1'b1;
        magnitude = W'(1234);
        sign_in   = 1'b0;
        accept_and_wait(3, lat);
        check_result(1234, 1'b0, lat);
        done_count = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (done) done_count++;
        end
        check("no_extra_done", 32'(done_count), 32'd0);
        check("idle_after_ignore", 32'(busy), 32'd0);

        // Reset at iteration 7 aborts
        @(negedge clock);
        start     = 1'b1;
        magnitude = W'(2468);
        sign_in   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_blank", 32'(blank), 32'd0);
        check("abort_sign", 32'(sign_out), 32'd0);
        last_bcd   = '0;
        last_blank = '0;
        done_count = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (done) done_count++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (done) done_count++;
        end
        check("abort_no_done", 32'(done_count), 32'd0);
        run_one(500, 1'b0);

        // Back-to-back: second start held during the first done cycle
        @(negedge clock);
        start     = 1'b1;
        magnitude = W'(9876);
        sign_in   = 1'b1;
        accept_and_wait(-1, lat);
        check_result(9876, 1'b1, lat);
        start     = 1'b1;
        magnitude = W'(7);
        sign_in   = 1'b0;
        accept_and_wait(-1, lat);
        check_result(7, 1'b0, lat);

        // Randomized conversions, biased toward small values for blanking
        for (int i = 0; i < 24; i++) begin
            m = (i % 3 == 0) ? $urandom_range(0, 99) : $urandom_range(0, 16383);
            s = 1'($urandom);
            run_one(m, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
